// File: rtl/wb_regfile.sv
// wb_regfile: integer register file with one writeback port, two decode read ports and a pending-write scoreboard (REGFILE_BYPASS_EN adds write-through bypass).
// Latency: reads, busy and issue_ready are combinational; data and scoreboard state update on the rising clk edge.
// Backpressure: issue_ready drops when a destination counter is saturated; an issue presented then is dropped and sb_overflow latches.
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      MEM_WB_rd,
    input  logic            MEM_WB_regwrite,
    input  logic [XLEN-1:0] MEM_WB_result,
    input  logic [4:0]      ID_rs1,
    input  logic [4:0]      ID_rs2,
    input  logic            ID_issue,
    input  logic [4:0]      ID_issue_rd,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            issue_ready,
    output logic            sb_overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Entry 0 is kept in reset and never written, reads of index 0 are forced to zero.
    logic [XLEN-1:0]  regs [NREG];
    logic [CNT_W-1:0] cnt  [NREG];

    logic wb_vld;
    logic inc;
    logic dec;
    logic same_rd;

    // Writeback qualification and scoreboard increment/decrement requests.
    always_comb begin
        wb_vld      = MEM_WB_regwrite && (MEM_WB_rd != 5'd0);
        issue_ready = (ID_issue_rd == 5'd0) || (cnt[ID_issue_rd] != CNT_MAX);
        inc         = ID_issue && issue_ready && (ID_issue_rd != 5'd0);
        dec         = wb_vld && (cnt[MEM_WB_rd] != '0);
        same_rd     = (MEM_WB_rd == ID_issue_rd);
    end

`ifdef REGFILE_BYPASS_EN
    logic rs1_wb;
    logic rs2_wb;

    // Read ports with write-through: a same-cycle writeback is visible immediately
    // and releases busy when it retires the last outstanding write.
    always_comb begin
        rs1_wb   = wb_vld && (MEM_WB_rd == ID_rs1);
        rs2_wb   = wb_vld && (MEM_WB_rd == ID_rs2);
        rs1_data = (ID_rs1 == 5'd0) ? '0 : (rs1_wb ? MEM_WB_result : regs[ID_rs1]);
        rs2_data = (ID_rs2 == 5'd0) ? '0 : (rs2_wb ? MEM_WB_result : regs[ID_rs2]);
        rs1_busy = (ID_rs1 != 5'd0) && (cnt[ID_rs1] != '0) && !(rs1_wb && (cnt[ID_rs1] == CNT_ONE));
        rs2_busy = (ID_rs2 != 5'd0) && (cnt[ID_rs2] != '0) && !(rs2_wb && (cnt[ID_rs2] == CNT_ONE));
    end
`else
    // Read ports from stored state only; a writeback becomes visible the cycle after.
    always_comb begin
        rs1_data = (ID_rs1 == 5'd0) ? '0 : regs[ID_rs1];
        rs2_data = (ID_rs2 == 5'd0) ? '0 : regs[ID_rs2];
        rs1_busy = (ID_rs1 != 5'd0) && (cnt[ID_rs1] != '0);
        rs2_busy = (ID_rs2 != 5'd0) && (cnt[ID_rs2] != '0);
    end
`endif

    // Register data commit; index 0 writes are discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (wb_vld) begin
            regs[MEM_WB_rd] <= MEM_WB_result;
        end
    end

    // Scoreboard counters: an issue and a retire on the same register cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            sb_overflow <= 1'b0;
        end else begin
            if (ID_issue && !issue_ready) begin
                sb_overflow <= 1'b1;
            end
            if (inc && !(dec && same_rd)) begin
                cnt[ID_issue_rd] <= cnt[ID_issue_rd] + CNT_ONE;
            end
            if (dec && !(inc && same_rd)) begin
                cnt[MEM_WB_rd] <= cnt[MEM_WB_rd] - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and randomized checks of wb_regfile against a behavioural model.
// Inputs change 1 time unit after the rising edge; outputs are compared at the falling edge.
// The model tracks pending writes as plain integer counts per register.
module tb_wb_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int CMAX = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  MEM_WB_rd;
    logic        MEM_WB_regwrite;
    logic [31:0] MEM_WB_result;
    logic [4:0]  ID_rs1;
    logic [4:0]  ID_rs2;
    logic        ID_issue;
    logic [4:0]  ID_issue_rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        issue_ready;
    logic        sb_overflow;

    wb_regfile #(.XLEN(32), .NREG(32), .CNT_W(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .MEM_WB_rd      (MEM_WB_rd),
        .MEM_WB_regwrite(MEM_WB_regwrite),
        .MEM_WB_result  (MEM_WB_result),
        .ID_rs1         (ID_rs1),
        .ID_rs2         (ID_rs2),
        .ID_issue       (ID_issue),
        .ID_issue_rd    (ID_issue_rd),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .rs1_busy       (rs1_busy),
        .rs2_busy       (rs2_busy),
        .issue_ready    (issue_ready),
        .sb_overflow    (sb_overflow)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;

    // Behavioural model state.
    logic [31:0] mreg [32];
    int          mcnt [32];
    bit          movf = 1'b0;
    bit          m_rdy;

    initial begin
        for (int i = 0; i < 32; i++) begin
            mreg[i] = '0;
            mcnt[i] = 0;
        end
    end

    function automatic logic [31:0] exp_data(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (BYP && MEM_WB_regwrite && MEM_WB_rd == idx) return MEM_WB_result;
        return mreg[idx];
    endfunction

    function automatic logic exp_busy(input logic [4:0] idx);
        if (idx == 5'd0) return 1'b0;
        if (mcnt[idx] == 0) return 1'b0;
        if (BYP && mcnt[idx] == 1 && MEM_WB_regwrite && MEM_WB_rd == idx) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_ready(input logic [4:0] idx);
        return (idx == 5'd0) || (mcnt[idx] < CMAX);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each rising edge from the inputs held across it.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mreg[i] = '0;
                mcnt[i] = 0;
            end
            movf = 1'b0;
        end else begin
            m_rdy = exp_ready(ID_issue_rd);
            if (ID_issue && !m_rdy) movf = 1'b1;
            if (MEM_WB_regwrite && MEM_WB_rd != 5'd0) begin
                if (mcnt[MEM_WB_rd] > 0) mcnt[MEM_WB_rd] = mcnt[MEM_WB_rd] - 1;
                mreg[MEM_WB_rd] = MEM_WB_result;
            end
            if (ID_issue && m_rdy && ID_issue_rd != 5'd0) mcnt[ID_issue_rd] = mcnt[ID_issue_rd] + 1;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rs1_data", rs1_data, exp_data(ID_rs1));
            chk("rs2_data", rs2_data, exp_data(ID_rs2));
            chk("rs1_busy", 32'(rs1_busy), 32'(exp_busy(ID_rs1)));
            chk("rs2_busy", 32'(rs2_busy), 32'(exp_busy(ID_rs2)));
            chk("issue_ready", 32'(issue_ready), 32'(exp_ready(ID_issue_rd)));
            chk("sb_overflow", 32'(sb_overflow), 32'(movf));
        end
    end

    task automatic apply(input logic we, input logic [4:0] rd, input logic [31:0] res,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic iss, input logic [4:0] ird);
        MEM_WB_regwrite = we;
        MEM_WB_rd       = rd;
        MEM_WB_result   = res;
        ID_rs1          = r1;
        ID_rs2          = r2;
        ID_issue        = iss;
        ID_issue_rd     = ird;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        apply(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
        next_cycle();
        chk_en = 1'b1;

        // Reset cycle carrying an issue and a writeback: both must be dropped.
        apply(1'b1, 5'd4, 32'h0000_0055, 5'd4, 5'd0, 1'b1, 5'd4);
        next_cycle();
        reset = 1'b0;
        apply(1'b0, 5'd0, 32'd0, 5'd4, 5'd4, 1'b0, 5'd4);
        @(negedge clk);
        chk("lit_rst_x4_data", rs1_data, 32'd0);
        chk("lit_rst_x4_busy", 32'(rs1_busy), 32'd0);
        chk("lit_rst_ready", 32'(issue_ready), 32'd1);
        chk("lit_rst_ovf", 32'(sb_overflow), 32'd0);
        next_cycle();

        // All indices read zero and idle after reset.
        for (int i = 0; i < 32; i++) begin
            apply(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0, 5'(i));
            @(negedge clk);
            chk("lit_rst_rs1", rs1_data, 32'd0);
            chk("lit_rst_rs2", rs2_data, 32'd0);
            chk("lit_rst_busy", 32'({rs1_busy, rs2_busy}), 32'd0);
            chk("lit_rst_rdy_i", 32'(issue_ready), 32'd1);
            next_cycle();
        end

        // Plain write then read; write to x0 is discarded.
        apply(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0, 5'd0);
        next_cycle();
        apply(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        chk("lit_x5", rs1_data, 32'hDEAD_BEEF);
        next_cycle();
        apply(1'b1, 5'd0, 32'h0000_1234, 5'd5, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        chk("lit_x0_wcyc", rs2_data, 32'd0);
        next_cycle();
        apply(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        chk("lit_x0_after", rs2_data, 32'd0);
        next_cycle();

        // Same-cycle write and read of x7.
        apply(1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        chk("lit_x7_same", rs1_data, BYP ? 32'hA5A5_A5A5 : 32'd0);
        next_cycle();
        apply(1'b0, 5'd0, 32'd0, 5'd7, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        chk("lit_x7_next", rs1_data, 32'hA5A5_A5A5);
        next_cycle();

        // Saturate x3's counter, overflow, then drain it.
        repeat (3) begin
            apply(1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 1'b1, 5'd3);
            next_cycle();
        end
        apply(1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 1'b0, 5'd3);
        @(negedge clk);
        chk("lit_x3_full_rdy", 32'(issue_ready), 32'd0);
        chk("lit_x3_busy", 32'(rs1_busy), 32'd1);
        chk("lit_x3_noovf", 32'(sb_overflow), 32'd0);
        next_cycle();
        apply(1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 1'b1, 5'd3);
        next_cycle();
        apply(1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 1'b0, 5'd3);
        @(negedge clk);
        chk("lit_x3_ovf", 32'(sb_overflow), 32'd1);
        chk("lit_x3_still_full", 32'(issue_ready), 32'd0);
        next_cycle();
        apply(1'b1, 5'd3, 32'h0000_0033, 5'd3, 5'd3, 1'b0, 5'd3);
        @(negedge clk);
        chk("lit_x3_wb1_busy", 32'(rs1_busy), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("lit_x3_wb2_busy", 32'(rs1_busy), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("lit_x3_wb3_busy", 32'(rs1_busy), BYP ? 32'd0 : 32'd1);
        next_cycle();
        apply(1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 1'b0, 5'd3);
        @(negedge clk);
        chk("lit_x3_idle_busy", 32'(rs1_busy), 32'd0);
        chk("lit_x3_idle_rdy", 32'(issue_ready), 32'd1);
        chk("lit_x3_ovf_sticky", 32'(sb_overflow), 32'd1);
        chk("lit_x3_data", rs1_data, 32'h0000_0033);
        next_cycle();

        // Issue and writeback on x9 in the same cycle leave its count at 1.
        apply(1'b0, 5'd0, 32'd0, 5'd9, 5'd9, 1'b1, 5'd9);
        next_cycle();
        apply(1'b1, 5'd9, 32'h0000_0099, 5'd9, 5'd9, 1'b1, 5'd9);
        @(negedge clk);
        chk("lit_x9_same_busy", 32'(rs1_busy), BYP ? 32'd0 : 32'd1);
        next_cycle();
        apply(1'b0, 5'd0, 32'd0, 5'd9, 5'd9, 1'b0, 5'd9);
        @(negedge clk);
        chk("lit_x9_next_busy", 32'(rs1_busy), 32'd1);
        next_cycle();
        apply(1'b1, 5'd9, 32'h0000_0999, 5'd9, 5'd9, 1'b0, 5'd9);
        next_cycle();

        // Randomized traffic concentrated on a few registers to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            apply(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
                  $urandom(),
                  5'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)));
            next_cycle();
        end
        reset = 1'b0;
        apply(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Architectural integer register file that sits at the consuming end of the writeback interface, after the MEM/WB pipeline register.
- Accepts the MEM_WB_rd / MEM_WB_regwrite / MEM_WB_result triple and commits it to storage.
- Serves two combinational read ports to decode.
- Holds a per-register pending-write scoreboard, set at issue and cleared at writeback, so decode can stall on RAW hazards.

Parameters:
XLEN, 32, data width of each register and of the read/write ports
NREG, 32, number of architectural registers; index 0 is hardwired zero
CNT_W, 2, width of each scoreboard counter; max in-flight writes per register = 2^CNT_W-1

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
MEM_WB_rd  input  5  writeback destination index
MEM_WB_regwrite  input  1  writeback enable
MEM_WB_result  input  XLEN  writeback data
ID_rs1  input  5  read port 1 index
ID_rs2  input  5  read port 2 index
ID_issue  input  1  decode issues an instruction that will write ID_issue_rd
ID_issue_rd  input  5  destination of the issuing instruction
rs1_data  output  XLEN  read port 1 data (combinational)
rs2_data  output  XLEN  read port 2 data (combinational)
rs1_busy  output  1  ID_rs1 has an uncommitted pending write
rs2_busy  output  1  ID_rs2 has an uncommitted pending write
issue_ready  output  1  scoreboard counter for ID_issue_rd is below max
sb_overflow  output  1  sticky error flag: issue attempted while issue_ready was low

Behaviour:
- Reset (synchronous, active-high): all registers, all counters and sb_overflow clear to 0 at the edge. A writeback or issue presented in the reset cycle is dropped.
- Write: at posedge, if MEM_WB_regwrite && MEM_WB_rd != 0, reg[MEM_WB_rd] <= MEM_WB_result. Writes to index 0 are discarded.
- Read: asynchronous, zero latency. Index 0 always returns 0.
- Scoreboard: cnt[r] is CNT_W bits, r = 1..NREG-1. Index 0 has no counter; busy for index 0 is always 0.
  - inc = ID_issue && issue_ready && ID_issue_rd != 0
  - dec = MEM_WB_regwrite && MEM_WB_rd != 0 && cnt[MEM_WB_rd] != 0
  - Same register, inc and dec in the same cycle: count is unchanged.
  - Different registers: both update independently.
  - Writeback to a register whose count is already 0 (untracked write): data is committed, counter stays 0, no error.
- issue_ready = (ID_issue_rd == 0) || cnt[ID_issue_rd] != max.
  - Combinational; does not account for a same-cycle decrement.
  - ID_issue while !issue_ready: no increment; sb_overflow sets and stays set until reset.
- rs busy (base) = cnt[rs] != 0, evaluated before the edge.
- Counter wrap-around is impossible by construction. A saturated issue is blocked and flagged.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined, read data: write-through bypass. If MEM_WB_regwrite && MEM_WB_rd != 0 && MEM_WB_rd == ID_rsN, rsN_data = MEM_WB_result in the same cycle.
- Defined, busy: rsN_busy is deasserted when cnt[rsN] == 1 and that register is being written back this cycle.
- Not defined: rsN_data returns the old stored value during the write cycle and the new value from the next cycle. rsN_busy = cnt[rsN] != 0 with no writeback qualification, so decode stalls one extra cycle.

Test Plan:
- Reset, then read all indices -> every rsN_data = 0, rsN_busy = 0, issue_ready = 1, sb_overflow = 0.
- Write x5 = 0xDEADBEEF, next cycle read rs1 = 5 -> 0xDEADBEEF. Write x0 = 0x1234 -> rs2 = 0 reads 0.
- Same-cycle write x7 = 0xA5A5A5A5 with rs1 = 7:
  - bypass build -> 0xA5A5A5A5 that cycle
  - non-bypass build -> old value that cycle, 0xA5A5A5A5 the next.
- Issue rd = 3 three times (CNT_W = 2), then issue_ready = 0. Fourth issue -> sb_overflow = 1, cnt stays 3. Three writebacks to x3 -> rs1_busy(3) falls after the third (same cycle with bypass, next cycle without).
- Issue rd = 9 and writeback rd = 9 in the same cycle with cnt[9] = 1 -> cnt stays 1, rs1_busy(9) stays 1 next cycle.
- Issue rd = 4 and writeback x4 asserted in the reset cycle -> after reset cnt[4] = 0, x4 = 0, sb_overflow = 0.
